uart_rx: RTL and testbench

- Serial receiver, the counterpart of the existing uart_tx.
- Samples the asynchronous i_rx line and deserialises 8N1 frames (1 start, 8 data LSB-first, 1 stop).
- Presents each received byte with a valid/ack handshake, to be consumed by the RX_REG path of the wishbone UART controller.
- Reports framing errors and overruns.

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/uart_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: frame width, default bit period and the
// receiver state encodings. The encodings are fixed 3-bit values so that
// they line up with the uart_tx side and with debug views of the state.
package uart_rx_pkg;

   localparam int UART_DATA_BITS       = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 434;   // 50 MHz / 115200 baud

   localparam logic [2:0] RX_IDLE  = 3'd0;
   localparam logic [2:0] RX_START = 3'd1;
   localparam logic [2:0] RX_DATA  = 3'd2;
   localparam logic [2:0] RX_STOP  = 3'd3;
   localparam logic [2:0] RX_BREAK = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = RX_IDLE,
      S_START = RX_START,
      S_DATA  = RX_DATA,
      S_STOP  = RX_STOP,
      S_BREAK = RX_BREAK
   } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, loads RESET_VAL into both flops
//   d     - asynchronous input
//   q     - synchronised output
module sync_2ff #(
   parameter int   WIDTH     = 1,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= {WIDTH{RESET_VAL}};
         q    <= {WIDTH{RESET_VAL}};
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ack handshake towards the RX register path.
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous active-low reset
//   i_rx        - serial line, idle high, asynchronous to clk
//   i_ack       - consumer has taken o_data; clears o_valid and o_overrun
//   o_data      - last accepted byte, held until the next accepted frame
//   o_valid     - high while an unconsumed byte sits in o_data
//   o_frame_err - one-cycle pulse when the stop bit is sampled low
//   o_overrun   - sticky, a good frame arrived while o_valid was high
//   o_busy      - high whenever the receiver is not idle
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on rx_s
// S_START | timing half a bit to the middle of the start bit
// S_DATA  | sampling 8 data bits LSB first, one per bit period
// S_STOP  | waiting one bit period to sample the stop bit
// S_BREAK | stop bit was low; wait for the line to go high again
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_rx,
   input  logic                      i_ack,
   output logic [UART_DATA_BITS-1:0] o_data,
   output logic                      o_valid,
   output logic                      o_frame_err,
   output logic                      o_overrun,
   output logic                      o_busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(UART_DATA_BITS);

   localparam logic [CNT_W-1:0] TC_FULL  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] TC_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

   logic                      rx_s;
   rx_state_e                 state, state_nxt;
   logic [CNT_W-1:0]          cnt, cnt_nxt;
   logic [IDX_W-1:0]          idx, idx_nxt;
   logic [UART_DATA_BITS-1:0] shift, shift_nxt;
   logic                      accept;
   logic                      frame_err_set;

   sync_2ff #(
      .WIDTH     (1),
      .RESET_VAL (1'b1)
   ) u_sync_rx (
      .clk   (clk),
      .rst_n (reset),
      .d     (i_rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         shift <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      idx_nxt       = idx;
      shift_nxt     = shift;
      accept        = 1'b0;
      frame_err_set = 1'b0;

      case (state)
         S_IDLE: begin
            if (!rx_s) begin
               state_nxt = S_START;
               cnt_nxt   = '0;
            end
         end

         S_START: begin
            if (cnt == TC_HALF) begin
               cnt_nxt = '0;
               if (!rx_s) begin
                  state_nxt = S_DATA;
                  idx_nxt   = '0;
               end else begin
                  // line went back high before mid start bit: glitch
                  state_nxt = S_IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         S_DATA: begin
            if (cnt == TC_FULL) begin
               cnt_nxt   = '0;
               shift_nxt = {rx_s, shift[UART_DATA_BITS-1:1]};
               idx_nxt   = idx + IDX_W'(1);
               if (idx == LAST_IDX) begin
                  state_nxt = S_STOP;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         S_STOP: begin
            if (cnt == TC_FULL) begin
               cnt_nxt = '0;
               // returning to idle mid stop bit lets a back-to-back
               // start bit be caught on its leading edge
               if (rx_s) begin
                  state_nxt = S_IDLE;
                  accept    = 1'b1;
               end else begin
                  state_nxt     = S_BREAK;
                  frame_err_set = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         S_BREAK: begin
            if (rx_s) begin
               state_nxt = S_IDLE;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Handshake: an ack in the same cycle as an accept frees the holding
   // register, so the new byte is taken instead of being counted as overrun.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         o_frame_err <= frame_err_set;
         if (accept) begin
            if (!o_valid || i_ack) begin
               o_data  <= shift;
               o_valid <= 1'b1;
            end else begin
               o_overrun <= 1'b1;
            end
         end else if (i_ack) begin
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
         end
      end
   end

   assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

   localparam int C   = 8;
   localparam int LAT = 2 + C/2 + 9*C + 1;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       i_rx  = 1'b1;
   logic       i_ack = 1'b0;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_frame_err;
   logic       o_overrun;
   logic       o_busy;

   int n_tests = 0;
   int n_fail  = 0;

   // frame-level reference model
   logic [7:0] m_data    = 8'h00;
   logic       m_valid   = 1'b0;
   logic       m_overrun = 1'b0;
   int         m_fe      = 0;

   // frame-error pulse monitor
   int fe_cnt     = 0;
   int fe_run     = 0;
   int fe_max_run = 0;

   uart_rx #(.CLKS_PER_BIT(C)) dut (
      .clk         (clk),
      .reset       (reset),
      .i_rx        (i_rx),
      .i_ack       (i_ack),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_frame_err (o_frame_err),
      .o_overrun   (o_overrun),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_frame_err) begin
         if (fe_run == 0) fe_cnt++;
         fe_run++;
         if (fe_run > fe_max_run) fe_max_run = fe_run;
      end else begin
         fe_run = 0;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_data    = 8'h00;
      m_valid   = 1'b0;
      m_overrun = 1'b0;
   endtask

   task automatic m_frame(input logic [7:0] b, input logic stop_ok, input logic ack_same);
      if (!stop_ok)                m_fe++;
      else if (!m_valid || ack_same) begin
         m_data  = b;
         m_valid = 1'b1;
      end else                     m_overrun = 1'b1;
   endtask

   task automatic m_ack();
      if (m_valid) begin
         m_valid   = 1'b0;
         m_overrun = 1'b0;
      end
   endtask

   task automatic check_model(input string tag);
      check_val({tag, ".valid"},   {31'd0, o_valid},   {31'd0, m_valid});
      check_val({tag, ".data"},    {24'd0, o_data},    {24'd0, m_data});
      check_val({tag, ".overrun"}, {31'd0, o_overrun}, {31'd0, m_overrun});
      check_val({tag, ".fe_count"}, fe_cnt, m_fe);
   endtask

   // Drives one 10-bit frame; edge k of the frame is the k-th rising edge
   // after i_rx first goes low. ack_edge!=0 raises i_ack for that edge.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_edge,
                             output int lat);
      logic [9:0] bits;
      int e;
      bits = {stop, b, 1'b0};
      e    = 0;
      lat  = 0;
      for (int k = 0; k < 10; k++) begin
         for (int j = 0; j < C; j++) begin
            @(negedge clk);
            i_rx  = bits[k];
            i_ack = (ack_edge != 0) && (e + 1 == ack_edge);
            @(posedge clk);
            e++;
            #1;
            if (lat == 0 && o_valid) lat = e;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         i_rx  = 1'b1;
         i_ack = 1'b0;
      end
   endtask

   task automatic do_ack();
      @(negedge clk);
      i_ack = 1'b1;
      @(posedge clk);
      #1;
      m_ack();
      @(negedge clk);
      i_ack = 1'b0;
   endtask

   initial begin
      int   lat;
      logic busy_all, seen_busy, busy_at7;

      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset.data",      {24'd0, o_data}, 0);
      check_val("reset.valid",     {31'd0, o_valid}, 0);
      check_val("reset.frame_err", {31'd0, o_frame_err}, 0);
      check_val("reset.overrun",   {31'd0, o_overrun}, 0);
      check_val("reset.busy",      {31'd0, o_busy}, 0);
      m_reset();
      @(negedge clk) reset = 1'b1;
      idle(5);

      // single byte, latency and delayed ack
      send_frame(8'h55, 1'b1, 0, lat);
      m_frame(8'h55, 1'b1, 1'b0);
      check_val("t1.latency", lat, LAT);
      check_model("t1");
      idle(2);
      do_ack();
      check_val("t1.valid_after_ack", {31'd0, o_valid}, 0);
      idle(3);

      // back-to-back frames without ack -> overrun
      send_frame(8'hA3, 1'b1, 0, lat);
      m_frame(8'hA3, 1'b1, 1'b0);
      send_frame(8'h0F, 1'b1, 0, lat);
      m_frame(8'h0F, 1'b1, 1'b0);
      check_model("t2");
      do_ack();
      check_model("t2.ack");
      idle(3);

      // bad stop bit with the line held low
      send_frame(8'h3C, 1'b0, 0, lat);
      m_frame(8'h3C, 1'b0, 1'b0);
      busy_all = 1'b1;
      repeat (40) begin
         @(negedge clk);
         i_rx = 1'b0;
         @(posedge clk);
         #1;
         busy_all &= o_busy;
      end
      check_val("t3.break_held", {31'd0, busy_all}, 1);
      check_model("t3");
      check_val("t3.fe_width", fe_max_run, 1);
      idle(4);
      check_val("t3.busy_released", {31'd0, o_busy}, 0);
      send_frame(8'h81, 1'b1, 0, lat);
      m_frame(8'h81, 1'b1, 1'b0);
      check_model("t3.next");
      do_ack();
      idle(3);

      // three-cycle glitch
      seen_busy = 1'b0;
      busy_at7  = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         @(negedge clk);
         i_rx = (e <= 3) ? 1'b0 : 1'b1;
         @(posedge clk);
         #1;
         if (o_busy) seen_busy = 1'b1;
         if (e == 7) busy_at7 = o_busy;
      end
      check_val("t4.busy_seen", {31'd0, seen_busy}, 1);
      check_val("t4.busy_at7",  {31'd0, busy_at7}, 0);
      check_model("t4");
      idle(3);

      // ack coinciding with accept while a byte is pending
      send_frame(8'h11, 1'b1, 0, lat);
      m_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h7E, 1'b1, LAT, lat);
      m_frame(8'h7E, 1'b1, 1'b1);
      check_model("t5");
      idle(2);

      // reset in the middle of a frame
      send_frame(8'h99, 1'b1, 0, lat);
      m_frame(8'h99, 1'b1, 1'b0);
      check_model("t6.pre");
      repeat (C) begin @(negedge clk); i_rx = 1'b0; end
      repeat (2*C) begin @(negedge clk); i_rx = 1'b1; end
      @(negedge clk);
      reset = 1'b0;
      #1;
      m_reset();
      check_val("t6.rst_data",    {24'd0, o_data}, 0);
      check_val("t6.rst_valid",   {31'd0, o_valid}, 0);
      check_val("t6.rst_overrun", {31'd0, o_overrun}, 0);
      check_val("t6.rst_busy",    {31'd0, o_busy}, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      idle(5);
      check_val("t6.idle_after", {31'd0, o_busy}, 0);
      send_frame(8'h12, 1'b1, 0, lat);
      m_frame(8'h12, 1'b1, 1'b0);
      check_model("t6.post");
      do_ack();
      idle(2);

      // random frames, random stop errors, random acks
      for (int n = 0; n < 30; n++) begin
         logic [7:0] b;
         logic       good;
         b    = 8'($urandom_range(0, 255));
         good = ($urandom_range(0, 99) < 80);
         send_frame(b, good, 0, lat);
         m_frame(b, good, 1'b0);
         check_model("rnd");
         if (!good) idle(4);
         else       idle($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) do_ack();
      end
      check_val("rnd.fe_width", fe_max_run, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
